// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// Module      : ifu
// Description : Instruction fetch unit. Owns the architectural PC, fetches one
//               instruction at a time from instruction memory and hands it to
//               decode over a valid/ready handshake. Updates the PC only when
//               decode consumes the held instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu #(
    parameter int               XLEN     = 64,
    parameter int               INST_W   = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    // Instruction memory request channel
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    // Instruction memory response channel
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    // Decode interface
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc,
    // Execute feedback
    input  logic [XLEN-1:0]   next_pc,
    input  logic              redirect,
    // Status
    output logic              fetch_misalign,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [XLEN-1:0]     r_pc;
    logic [INST_W-1:0]   r_inst;
    logic [31:0]         r_cnt;

    logic                w_latch;    // capture response data this cycle
    logic                w_consume;  // decode takes the held instruction
    logic [XLEN-1:0]     w_pc_upd;   // PC chosen at consumption

    // Sequential PC target: jump target when execute redirects, else PC+4
    // (the add wraps naturally at 2^XLEN).
    assign w_pc_upd = redirect ? next_pc : (r_pc + XLEN'(4));

    // Next-state and handshake decode; responses outside WAIT are ignored.
    always_comb begin
        w_state_next   = r_state;
        w_latch        = 1'b0;
        w_consume      = 1'b0;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        case (r_state)
            S_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    w_latch      = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    w_consume    = 1'b1;
                    w_state_next = (w_pc_upd[1:0] != 2'b00) ? S_FAULT : S_REQ;
                end
            end
            S_FAULT: begin
                w_state_next = S_FAULT;
            end
            default: begin
                w_state_next = S_REQ;
            end
        endcase
    end

    // State, PC, held instruction and consumption counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_inst <= imem_resp_data;
            end
            if (w_consume) begin
                r_pc  <= w_pc_upd;
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    assign imem_req_addr  = r_pc;
    assign inst           = r_inst;
    assign inst_pc        = r_pc;
    assign fetch_misalign = (r_state == S_FAULT);
    assign fetch_cnt      = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu
// Description : Directed self-checking bench for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [63:0] next_pc;
    logic        redirect;
    logic        fetch_misalign;
    logic [31:0] fetch_cnt;

    int errors = 0;
    int checks = 0;

    ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .next_pc         (next_pc),
        .redirect        (redirect),
        .fetch_misalign  (fetch_misalign),
        .fetch_cnt       (fetch_cnt)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Advance one cycle; outputs are then sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full fetch with an immediately ready memory and a one-cycle response;
    // the instruction is consumed in its first HOLD cycle with the given
    // redirect/next_pc. Entered and left in a cycle sampled just after an edge.
    task automatic fetch(input string tag, input logic [63:0] addr, input logic [31:0] data,
                         input logic rd, input logic [63:0] npc);
        imem_req_ready = 1'b1;
        chk({tag, ".req_valid"}, {63'd0, imem_req_valid}, 64'd1);
        chk({tag, ".req_addr"},  imem_req_addr, addr);
        step();                                   // accepted -> WAIT
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        chk({tag, ".wait_req_valid"}, {63'd0, imem_req_valid}, 64'd0);
        chk({tag, ".wait_inst_valid"}, {63'd0, inst_valid}, 64'd0);
        step();                                   // response -> HOLD
        imem_resp_valid = 1'b0;
        chk({tag, ".inst_valid"}, {63'd0, inst_valid}, 64'd1);
        chk({tag, ".inst_pc"}, inst_pc, addr);
        chk({tag, ".inst"}, {32'd0, inst}, {32'd0, data});
        inst_ready = 1'b1;
        redirect   = rd;
        next_pc    = npc;
        step();                                   // consumed
        inst_ready = 1'b0;
        redirect   = 1'b0;
        next_pc    = 64'd0;
    endtask

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        inst_ready      = 1'b0;
        next_pc         = 64'd0;
        redirect        = 1'b0;
        step();
        step();

        // Reset values
        chk("rst.pc",        inst_pc, 64'h8000_0000);
        chk("rst.inst",      {32'd0, inst}, 64'd0);
        chk("rst.cnt",       {32'd0, fetch_cnt}, 64'd0);
        chk("rst.misalign",  {63'd0, fetch_misalign}, 64'd0);
        chk("rst.inst_valid",{63'd0, inst_valid}, 64'd0);

        // 1/2. Sequential stream from reset; first request in first cycle
        rst = 1'b0;
        fetch("seq0", 64'h8000_0000, 32'h0000_0413, 1'b0, 64'd0);
        chk("seq0.cnt", {32'd0, fetch_cnt}, 64'd1);
        fetch("seq1", 64'h8000_0004, 32'h0010_0093, 1'b0, 64'd0);
        // 3. Jump taken while consuming the instruction at 0x80000008
        fetch("seq2", 64'h8000_0008, 32'h0f80_006f, 1'b1, 64'h8000_0100);
        chk("seq.cnt3",   {32'd0, fetch_cnt}, 64'd3);
        chk("jmp.addr",   imem_req_addr, 64'h8000_0100);
        chk("jmp.valid",  {63'd0, imem_req_valid}, 64'd1);

        // 4a. Request not accepted for 4 cycles: address held in REQ
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_req.valid", {63'd0, imem_req_valid}, 64'd1);
            chk("stall_req.addr",  imem_req_addr, 64'h8000_0100);
        end
        imem_req_ready = 1'b1;
        step();                                   // accepted -> WAIT
        // 4b. Response delayed 5 cycles
        for (int i = 0; i < 5; i++) begin
            chk("stall_resp.inst_valid", {63'd0, inst_valid}, 64'd0);
            chk("stall_resp.req_valid",  {63'd0, imem_req_valid}, 64'd0);
            step();
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        step();                                   // -> HOLD
        // 4c. Decode backpressure; stray response and redirect are ignored
        imem_resp_data = 32'h1234_5678;
        redirect       = 1'b1;
        next_pc        = 64'h8000_0200;
        for (int i = 0; i < 3; i++) begin
            chk("stall_dec.inst_valid", {63'd0, inst_valid}, 64'd1);
            chk("stall_dec.inst",       {32'd0, inst}, 64'hDEAD_BEEF);
            chk("stall_dec.inst_pc",    inst_pc, 64'h8000_0100);
            chk("stall_dec.req_valid",  {63'd0, imem_req_valid}, 64'd0);
            step();
        end
        imem_resp_valid = 1'b0;
        redirect        = 1'b0;
        next_pc         = 64'd0;
        inst_ready      = 1'b1;
        step();                                   // consumed -> REQ
        inst_ready = 1'b0;
        chk("stall_dec.next_addr", imem_req_addr, 64'h8000_0104);
        chk("stall_dec.cnt",       {32'd0, fetch_cnt}, 64'd4);

        // 7. PC+4 wraps modulo 2^64
        fetch("wrap0", 64'h8000_0104, 32'h0000_0013, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch("wrap1", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013, 1'b0, 64'd0);
        chk("wrap.addr", imem_req_addr, 64'd0);
        chk("wrap.misalign", {63'd0, fetch_misalign}, 64'd0);

        // 5. Misaligned jump target -> sticky FAULT
        fetch("mis", 64'd0, 32'h0000_0067, 1'b1, 64'h8000_0102);
        chk("mis.flag",       {63'd0, fetch_misalign}, 64'd1);
        chk("mis.req_valid",  {63'd0, imem_req_valid}, 64'd0);
        chk("mis.inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("mis.pc",         inst_pc, 64'h8000_0102);
        chk("mis.cnt",        {32'd0, fetch_cnt}, 64'd7);
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b1;
        inst_ready      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mis.sticky",    {63'd0, fetch_misalign}, 64'd1);
            chk("mis.no_req",    {63'd0, imem_req_valid}, 64'd0);
            chk("mis.pc_held",   inst_pc, 64'h8000_0102);
        end
        imem_resp_valid = 1'b0;
        inst_ready      = 1'b0;
        imem_req_ready  = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mis_rst.pc",       inst_pc, 64'h8000_0000);
        chk("mis_rst.misalign", {63'd0, fetch_misalign}, 64'd0);
        chk("mis_rst.cnt",      {32'd0, fetch_cnt}, 64'd0);
        chk("mis_rst.req",      {63'd0, imem_req_valid}, 64'd1);

        // 6. Reset while a response is outstanding
        imem_req_ready = 1'b1;
        step();                                   // accepted -> WAIT
        imem_req_ready = 1'b0;
        chk("rstw.in_wait", {63'd0, imem_req_valid}, 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw.req_valid",  {63'd0, imem_req_valid}, 64'd1);
        chk("rstw.inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rstw.pc",         inst_pc, 64'h8000_0000);
        chk("rstw.inst",       {32'd0, inst}, 64'd0);
        imem_resp_valid = 1'b1;                   // late response in REQ
        imem_resp_data  = 32'hCAFE_F00D;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rstw.late_inst_valid", {63'd0, inst_valid}, 64'd0);
            chk("rstw.late_req_valid",  {63'd0, imem_req_valid}, 64'd1);
            chk("rstw.late_inst",       {32'd0, inst}, 64'd0);
        end
        imem_resp_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit for the NPC core; sits directly upstream of the decode/execute path.
- Owns the architectural PC and fetches one 32-bit instruction at a time over a valid/ready request and response interface to instruction memory.
- Presents the instruction and its PC to decode with a valid/ready handshake.
- On consumption, updates the PC from the execute stage's next-PC/redirect outputs (jumps) or to PC+4.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset
XLEN, 64, PC/address width
INST_W, 32, instruction width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address (= pc)
imem_resp_valid  input  1  fetch data valid
imem_resp_data  input  INST_W  fetched instruction
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode/execute consumes instruction this cycle
inst  output  INST_W  held instruction
inst_pc  output  XLEN  PC of held instruction
next_pc  input  XLEN  target PC from execute, same cycle as consumption
redirect  input  1  execute PC write enable (jump taken)
fetch_misalign  output  1  sticky fault: PC[1:0] != 0
fetch_cnt  output  32  number of instructions consumed, wraps at 2^32

Behaviour:
- Synchronous reset, active-high, sampled on the rising edge of clk.
- Reset values:
  - state=REQ, pc=RESET_PC, inst=0, fetch_cnt=0, fetch_misalign=0.
  - imem_req_valid asserts in the first cycle after reset is released.
- States: REQ, WAIT, HOLD, FAULT.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc; both stay stable until accepted.
  - imem_req_valid && imem_req_ready -> WAIT.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid: latch imem_resp_data into inst -> HOLD.
  - The response arrives no earlier than the cycle after acceptance. A response in the acceptance cycle is a protocol violation; the unit ignores it.
- HOLD:
  - inst_valid=1; inst and inst_pc (=pc) stay stable until inst_ready.
  - On inst_valid && inst_ready:
    - pc <= redirect ? next_pc : pc+4.
    - fetch_cnt <= fetch_cnt+1.
    - If the new pc has [1:0] != 0 -> FAULT; otherwise -> REQ.
- FAULT:
  - fetch_misalign=1; all valids 0; pc holds the faulting value.
  - Remains in FAULT until rst.
- inst_valid is 1 only in HOLD. imem_req_valid is 1 only in REQ.
- imem_resp_valid is ignored in every state except WAIT.
- pc+4 wraps modulo 2^XLEN.
- Minimum latency:
  - Request accepted in cycle t, response in t+1, inst_valid in t+2.
  - If consumed in t+2, the next request is issued in t+3.
  - Peak throughput: 1 instruction per 3 cycles.
- Consumption is the only PC update point. redirect and next_pc are ignored outside the consuming cycle.
- Reset mid-operation (any state, including WAIT with a response outstanding): return to reset values next cycle. Instruction memory shares rst, so no stale response is delivered after reset.
- fetch_cnt wraps 0xFFFF_FFFF -> 0 without affecting other state.
- Backpressure: inst_ready low in HOLD holds everything, with no new fetch issued.

Test Plan:
1. Reset then idle memory (req_ready=1, 1-cycle response 0x00000413):
   - imem_req_addr=0x80000000 on the first post-reset cycle.
   - inst_valid on the 3rd cycle with inst_pc=0x80000000.
   - Next addr 0x80000004.
2. Sequential stream, inst_ready=1 always, redirect=0:
   - Addresses 0x80000000, 0x80000004, 0x80000008 spaced 3 cycles apart.
   - fetch_cnt=3 after the third consumption.
3. Jump: consume inst at 0x80000008 with redirect=1, next_pc=0x80000100:
   - Next imem_req_addr=0x80000100; no request to 0x8000000C.
4. Stalls:
   - req_ready low for 4 cycles: addr stable, state stays REQ.
   - Response delayed 5 cycles: inst_valid stays 0.
   - inst_ready low 3 cycles: inst/inst_pc stable, no new request.
5. Misalign: redirect=1, next_pc=0x80000102:
   - fetch_misalign=1 next cycle, no further requests.
   - Stays set until rst; rst restores pc=0x80000000 and fetch_misalign=0.
6. Reset in WAIT: assert rst while a response is outstanding:
   - Next cycle shows reset values.
   - A late imem_resp_valid in REQ is ignored (inst_valid stays 0).
